smachine_sequencer: RTL and testbench
=====================================

# smachine_sequencer

Instruction sequencer and memory-port arbiter for the S-Machine CPU. Owns the single memory port and shares it between instruction fetch and the datapath's LD/ST accesses. Holds the program counter and instruction register, and issues one execute strobe per instruction to the datapath. Sits between the memory and the instruction interpreter datapath, replacing free-running fetch with a handshaked sequence.

## Interface
- `TIMEOUT`, 64: maximum cycles a memory request may wait for `mem_ack` before a bus error (≥2).
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level enable. Starts from IDLE, and must drop low to leave HALT.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_ack` in 1: memory acknowledge, sampled on `clk` rising edge.
- `mem_rw` out 1: 0 = read, 1 = write.
- `mem_addr` out 8: memory address.
- `mem_wdata` out 16: write data.
- `mem_rdata` in 16: read data, valid in the `mem_ack` cycle.
- `dp_st_data` in 16: store operand from the datapath (A or B, selected by the datapath from `inst[11]`).
- `inst` out 16: instruction register.
- `inst_valid` out 1: one-cycle execute strobe to the datapath.
- `ld_data` out 16: data returned by a memory LD.
- `ld_valid` out 1: qualifies `ld_data`; high together with `inst_valid` for memory LD only.
- `pc` out 8: program counter (address of the next fetch).
- `halted` out 1: sequencer is in HALT.
- `bus_err` out 1: sticky flag, set by a memory timeout.

## Operation
- **Opcodes:**
  - LD = 4'b0000. Memory form when `inst[10]`=0; immediate form when `inst[10]`=1.
  - ST = 4'b0001.
  - HALT = 4'b1111.
  - All other opcodes are register-only.
- **States:** IDLE, FETCH, DECODE, MEM_RD, MEM_WR, EXEC, HALT.
- **IDLE:** go to FETCH when `run`=1.
- **FETCH:**
  - Drive `mem_req`=1, `mem_rw`=0, `mem_addr`=`pc`.
  - On ack: `inst`←`mem_rdata`, `pc`←`pc`+1 (mod 256, so 255 wraps to 0), go to DECODE.
- **DECODE:**
  - HALT opcode → HALT.
  - LD with `inst[10]`=0 → MEM_RD.
  - ST → MEM_WR, capturing `dp_st_data` into the write-data register on this transition.
  - Everything else → EXEC.
- **MEM_RD:**
  - Drive `mem_req`=1, `mem_rw`=0, `mem_addr`=`inst[7:0]`.
  - On ack: `ld_data`←`mem_rdata`, go to EXEC.
- **MEM_WR:**
  - Drive `mem_req`=1, `mem_rw`=1, `mem_addr`=`inst[7:0]`, `mem_wdata`=captured data.
  - On ack: go to EXEC.
- **EXEC:**
  - `inst_valid`=1 for exactly one cycle. `ld_valid`=1 only if the previous state was MEM_RD.
  - Then go to FETCH if `run`=1, otherwise to IDLE.
- **HALT:**
  - `halted`=1.
  - Go to IDLE when `run`=0. Restart therefore requires `run` to go low, then high.
  - `pc` already points past the HALT instruction.
- **Timeout:**
  - A wait counter is cleared on entry to FETCH, MEM_RD and MEM_WR, and counts each cycle that `mem_req`=1 and `mem_ack`=0.
  - When it reaches `TIMEOUT`: drop `mem_req`, set `bus_err`=1, go to HALT.
  - `bus_err` clears only on reset.

## Timing
- **Reset values:**
  - Outputs: `mem_req`, `mem_rw`, `mem_addr`, `mem_wdata`, `inst`, `inst_valid`, `ld_data`, `ld_valid`, `pc`, `halted`, `bus_err` all 0.
  - State: IDLE.
- **Reset assertion mid-transaction:** drops `mem_req` immediately (asynchronously) and abandons the access. No partial update of `inst`, `pc` or `ld_data`.
- **Handshake:**
  - `mem_addr`, `mem_rw` and `mem_wdata` are stable for as long as `mem_req`=1.
  - A transfer completes on a rising edge where `mem_req`=`mem_ack`=1. `mem_req` is low in the following cycle.
  - Zero-wait memory (ack in the first request cycle) is legal.
  - `mem_ack` while `mem_req`=0 is ignored.
  - `mem_req` is never high in two consecutive transactions without an intervening low cycle (DECODE/EXEC guarantee this).
- **Latency with zero-wait memory:**
  - Register-only or immediate-LD instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Memory LD/ST: 4 cycles.
  - Each wait cycle adds 1.
- **`run` in EXEC:** sampled in EXEC only. Deasserting `run` mid-instruction completes the current instruction.
- **Register outputs:** `inst`, `pc` and `ld_data` are registered. `inst` is stable from DECODE through EXEC.

## Structure
- **Package `smachine_pkg`:**
  - Opcode constants OP_LD, OP_ST, OP_HALT.
  - Bit-position constants for the `inst[11]` register select and `inst[10]` immediate flag.
  - State enum `seq_state_t`.
  - Memory read/write encoding constants RW_READ=0, RW_WRITE=1.
- **Sub-module `bus_timeout_counter`:**
  - Inputs: clear, count-enable.
  - Output: `expired` at `TIMEOUT`.
- **Top level:** the FSM and registers stay in `smachine_sequencer`.

## Test plan
- **Reset and start:** reset, `run`=1, memory[0]=16'h4000 (ADD), zero-wait → fetch at addr 0, `inst_valid` pulses in the 3rd cycle, `pc`=1, `ld_valid`=0.
- **Memory LD with wait states:** memory[1]=16'h0020 (LD A,[0x20]), memory[0x20]=16'hBEEF, ack after 2 wait cycles → read at 0x20, `ld_data`=16'hBEEF, `ld_valid` and `inst_valid` high together in one cycle.
- **ST:** 16'h1830 (ST B,[0x30]), `dp_st_data`=16'h1234 → write request with `mem_rw`=1, `mem_addr`=0x30, `mem_wdata`=16'h1234 stable until ack.
- **HALT, PC wrap and restart:**
  - 16'hF000 at addr 255 → `halted`=1, `pc`=0, no `inst_valid`.
  - Hold `run`=1: stays halted.
  - Drop then raise `run`: fetch resumes at 0.
- **Timeout, then reset:** never ack a fetch, `TIMEOUT`=64 → `mem_req` drops after 64 request cycles, `bus_err`=1, `halted`=1. Assert `rst_n`=0 during a later pending fetch → `mem_req`=0 at once, all outputs 0.

Source files
------------

// File: rtl/smachine_pkg.sv
// ---------------------------------------------------------------------------
// smachine_pkg
// Shared definitions for the S-Machine instruction sequencer:
//   - opcode constants (LD, ST, HALT) and instruction bit positions
//   - memory read/write encoding
//   - sequencer state enumeration
//   - opcode extraction helper
// ---------------------------------------------------------------------------
package smachine_pkg;

    localparam logic [3:0] OP_LD   = 4'b0000;
    localparam logic [3:0] OP_ST   = 4'b0001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // inst[11] selects A/B as the store source (used by the datapath),
    // inst[10] marks the immediate form of LD.
    localparam int INST_REGSEL_BIT = 11;
    localparam int INST_IMM_BIT    = 10;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM_RD = 3'd3,
        MEM_WR = 3'd4,
        EXEC   = 3'd5,
        HALT   = 3'd6
    } seq_state_t;

    // The opcode lives in the top nibble of every instruction word.
    function automatic logic [3:0] opcode_of(input logic [15:0] instWord);
        return instWord[15:12];
    endfunction

endpackage

// File: rtl/smachine_sequencer_if.sv
// ---------------------------------------------------------------------------
// smachine_sequencer_if
// Single memory port shared by instruction fetch and LD/ST data accesses.
//   mem_req   : request, held until acknowledged (master -> slave)
//   mem_ack   : acknowledge, transfer completes when req and ack are high
//   mem_rw    : 0 = read, 1 = write
//   mem_addr  : 8-bit word address
//   mem_wdata : write data
//   mem_rdata : read data, valid in the ack cycle
// Modports:
//   master : the sequencer
//   slave  : the memory
// ---------------------------------------------------------------------------
interface smachine_sequencer_if;

    logic        mem_req;
    logic        mem_ack;
    logic        mem_rw;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_rw,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_rw,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/smachine_sequencer_bus_timeout_counter.sv
// ---------------------------------------------------------------------------
// bus_timeout_counter
// Counts the cycles a memory request has been waiting for its acknowledge.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   clear_i    : zero the count (held while no request is outstanding)
//   count_en_i : one more waiting cycle (request high, ack low)
//   expired_o  : high in the waiting cycle that brings the count to TIMEOUT
// ---------------------------------------------------------------------------
module bus_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // The count holds the number of waiting cycles already completed, so
    // the current waiting cycle is the TIMEOUT-th one when the stored
    // count is TIMEOUT-1. Flagging it combinationally lets the sequencer
    // abandon the request on exactly that edge.
    assign expired_o = count_en_i && (count_q == W'(TIMEOUT - 1));

    // Next count: clear wins, otherwise step on each waiting cycle and
    // saturate once expired so the register can never wrap.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/smachine_sequencer.sv
// ---------------------------------------------------------------------------
// smachine_sequencer
// Instruction sequencer and memory-port arbiter for the S-Machine CPU.
// Owns the single memory port, shares it between instruction fetch and
// LD/ST data accesses, holds PC and instruction register, and issues one
// execute strobe per instruction to the datapath.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : level enable (start from IDLE, must drop to leave HALT)
//   mem         : memory port (master side)
//   dp_st_data  : store operand from the datapath
//   inst        : instruction register
//   inst_valid  : one-cycle execute strobe
//   ld_data     : data returned by a memory LD
//   ld_valid    : qualifies ld_data, coincident with inst_valid
//   pc          : address of the next fetch
//   halted      : sequencer is in HALT
//   bus_err     : sticky memory-timeout flag
// ---------------------------------------------------------------------------
module smachine_sequencer
    import smachine_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        run,
    smachine_sequencer_if.master        mem,
    input  logic [15:0]                 dp_st_data,
    output logic [15:0]                 inst,
    output logic                        inst_valid,
    output logic [15:0]                 ld_data,
    output logic                        ld_valid,
    output logic [7:0]                  pc,
    output logic                        halted,
    output logic                        bus_err
);

    seq_state_t  state_q;
    seq_state_t  state_d;
    logic [7:0]  pc_q;
    logic [7:0]  pc_d;
    logic [15:0] inst_q;
    logic [15:0] inst_d;
    logic [15:0] ldData_q;
    logic [15:0] ldData_d;
    logic [15:0] wdata_q;
    logic [15:0] wdata_d;
    logic        busErr_q;
    logic        busErr_d;
    logic        fromMemRd_q;
    logic        fromMemRd_d;

    logic        reqActive;
    logic        timeoutExpired;

    // The request is a pure decode of the state register, so an
    // asynchronous reset back to IDLE drops it immediately.
    assign reqActive = (state_q == FETCH) || (state_q == MEM_RD) ||
                       (state_q == MEM_WR);
    assign mem.mem_req = reqActive;

    // Outside the request states the counter is held clear, which makes
    // every entry into FETCH/MEM_RD/MEM_WR start from zero.
    bus_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (!reqActive),
        .count_en_i (reqActive && !mem.mem_ack),
        .expired_o  (timeoutExpired)
    );

    assign inst    = inst_q;
    assign pc      = pc_q;
    assign ld_data = ldData_q;
    assign bus_err = busErr_q;

    // Next-state and output decode. Registers only change on a completed
    // transfer or on a state transition, so mem_addr/mem_rw/mem_wdata stay
    // constant for the whole life of a request. An ack arriving in the same
    // cycle as the timeout wins: the transfer is complete.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        ldData_d      = ldData_q;
        wdata_d       = wdata_q;
        busErr_d      = busErr_q;
        fromMemRd_d   = fromMemRd_q;
        mem.mem_rw    = RW_READ;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        inst_valid    = 1'b0;
        ld_valid      = 1'b0;
        halted        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                mem.mem_addr = pc_q;
                if (mem.mem_ack) begin
                    inst_d  = mem.mem_rdata;
                    pc_d    = pc_q + 8'd1;
                    state_d = DECODE;
                end else if (timeoutExpired) begin
                    busErr_d = 1'b1;
                    state_d  = HALT;
                end
            end

            DECODE: begin
                if (opcode_of(inst_q) == OP_HALT) begin
                    state_d = HALT;
                end else if ((opcode_of(inst_q) == OP_LD) &&
                             !inst_q[INST_IMM_BIT]) begin
                    state_d = MEM_RD;
                end else if (opcode_of(inst_q) == OP_ST) begin
                    wdata_d = dp_st_data;
                    state_d = MEM_WR;
                end else begin
                    state_d = EXEC;
                end
            end

            MEM_RD: begin
                mem.mem_addr = inst_q[7:0];
                if (mem.mem_ack) begin
                    ldData_d    = mem.mem_rdata;
                    fromMemRd_d = 1'b1;
                    state_d     = EXEC;
                end else if (timeoutExpired) begin
                    busErr_d = 1'b1;
                    state_d  = HALT;
                end
            end

            MEM_WR: begin
                mem.mem_rw    = RW_WRITE;
                mem.mem_addr  = inst_q[7:0];
                mem.mem_wdata = wdata_q;
                if (mem.mem_ack) begin
                    state_d = EXEC;
                end else if (timeoutExpired) begin
                    busErr_d = 1'b1;
                    state_d  = HALT;
                end
            end

            EXEC: begin
                inst_valid  = 1'b1;
                ld_valid    = fromMemRd_q;
                fromMemRd_d = 1'b0;
                state_d     = run ? FETCH : IDLE;
            end

            HALT: begin
                halted = 1'b1;
                if (!run) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; everything returns to zero/IDLE on
    // reset, abandoning any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            inst_q      <= '0;
            ldData_q    <= '0;
            wdata_q     <= '0;
            busErr_q    <= 1'b0;
            fromMemRd_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            ldData_q    <= ldData_d;
            wdata_q     <= wdata_d;
            busErr_q    <= busErr_d;
            fromMemRd_q <= fromMemRd_d;
        end
    end

endmodule

// File: tb/tb_smachine_sequencer.sv
// ---------------------------------------------------------------------------
// tb_smachine_sequencer
// Directed bench for smachine_sequencer: a table of instructions run back
// to back against a behavioural memory with programmable wait states, plus
// hand-written sequences for HALT/PC wrap/restart and timeout/async reset.
// ---------------------------------------------------------------------------
module tb_smachine_sequencer;
    import smachine_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [15:0] dp_st_data;
    logic [15:0] inst;
    logic        inst_valid;
    logic [15:0] ld_data;
    logic        ld_valid;
    logic [7:0]  pc;
    logic        halted;
    logic        bus_err;

    smachine_sequencer_if memIf();

    smachine_sequencer #(
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .mem        (memIf),
        .dp_st_data (dp_st_data),
        .inst       (inst),
        .inst_valid (inst_valid),
        .ld_data    (ld_data),
        .ld_valid   (ld_valid),
        .pc         (pc),
        .halted     (halted),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    logic [15:0] memArr [256];
    int          ackDelay  = 0;
    int          waitCnt   = 0;
    bit          ackEnable = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic        lastTxnRw   = 1'b0;
    logic [7:0]  lastTxnAddr = '0;
    logic [15:0] lastTxnData = '0;
    int          protoErrors = 0;
    logic        prevReq     = 1'b0;
    logic        prevDone    = 1'b0;
    logic [7:0]  heldAddr    = '0;
    logic        heldRw      = 1'b0;
    logic [15:0] heldWdata   = '0;

    typedef struct {
        logic [15:0] word;
        logic [15:0] stData;
        int          waits;
        int          expGap;
        logic [7:0]  expPc;
        logic        expLdValid;
        logic [15:0] expLdData;
        logic        expRw;
        logic [7:0]  expAddr;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs [8];

    // Behavioural memory: acknowledges after ackDelay waiting cycles,
    // driving read data together with the ack.
    always @(negedge clk) begin
        if (memIf.mem_req && ackEnable) begin
            if (waitCnt >= ackDelay) begin
                memIf.mem_ack   = 1'b1;
                memIf.mem_rdata = memArr[memIf.mem_addr];
            end else begin
                memIf.mem_ack = 1'b0;
                waitCnt++;
            end
        end else begin
            memIf.mem_ack = 1'b0;
            waitCnt       = 0;
        end
    end

    // Bus monitor: logs completed transfers, commits writes, and counts
    // protocol breaks (request attributes changing mid-request, or a new
    // request immediately after a completed one).
    always @(posedge clk) begin
        if (rst_n) begin
            if (memIf.mem_req) begin
                if (prevDone) begin
                    protoErrors++;
                end
                if (prevReq && !prevDone) begin
                    if (memIf.mem_addr !== heldAddr || memIf.mem_rw !== heldRw ||
                        memIf.mem_wdata !== heldWdata) begin
                        protoErrors++;
                    end
                end
                heldAddr  = memIf.mem_addr;
                heldRw    = memIf.mem_rw;
                heldWdata = memIf.mem_wdata;
            end
            if (memIf.mem_req && memIf.mem_ack) begin
                lastTxnRw   = memIf.mem_rw;
                lastTxnAddr = memIf.mem_addr;
                lastTxnData = memIf.mem_rw ? memIf.mem_wdata : memIf.mem_rdata;
                if (memIf.mem_rw) begin
                    memArr[memIf.mem_addr] = memIf.mem_wdata;
                end
            end
            prevDone = memIf.mem_req && memIf.mem_ack;
            prevReq  = memIf.mem_req;
        end else begin
            prevDone = 1'b0;
            prevReq  = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int waits, input logic [15:0] stData);
        ackDelay   = waits;
        dp_st_data = stData;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " mem_req"},    32'(memIf.mem_req),   32'h0);
        checkOutput({tag, " mem_rw"},     32'(memIf.mem_rw),    32'h0);
        checkOutput({tag, " mem_addr"},   32'(memIf.mem_addr),  32'h0);
        checkOutput({tag, " mem_wdata"},  32'(memIf.mem_wdata), 32'h0);
        checkOutput({tag, " inst"},       32'(inst),            32'h0);
        checkOutput({tag, " inst_valid"}, 32'(inst_valid),      32'h0);
        checkOutput({tag, " ld_data"},    32'(ld_data),         32'h0);
        checkOutput({tag, " ld_valid"},   32'(ld_valid),        32'h0);
        checkOutput({tag, " pc"},         32'(pc),              32'h0);
        checkOutput({tag, " halted"},     32'(halted),          32'h0);
        checkOutput({tag, " bus_err"},    32'(bus_err),         32'h0);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        int gap;
        int pulses;
        int n;
        int reqCycles;
        bit sawReq;

        rst_n           = 1'b0;
        run             = 1'b0;
        dp_st_data      = '0;
        memIf.mem_ack   = 1'b0;
        memIf.mem_rdata = '0;

        // Program for the table: addresses 0..7, data at 0x20/0x40.
        for (int a = 0; a < 256; a++) memArr[a] = 16'h0000;
        memArr[0]    = 16'h4000;
        memArr[1]    = 16'h0020;
        memArr[2]    = 16'h1830;
        memArr[3]    = 16'h0455;
        memArr[4]    = 16'h0040;
        memArr[5]    = 16'h1041;
        memArr[6]    = 16'h2307;
        memArr[7]    = 16'h0041;
        memArr[8'h20] = 16'hBEEF;
        memArr[8'h40] = 16'hA5A5;

        //          word      stData    wt gap pc     ldv   ldData    rw        addr   data
        vecs[0] = '{16'h4000, 16'h0000, 0, 3, 8'h01, 1'b0, 16'h0000, RW_READ,  8'h00, 16'h4000};
        vecs[1] = '{16'h0020, 16'h0000, 2, 8, 8'h02, 1'b1, 16'hBEEF, RW_READ,  8'h20, 16'hBEEF};
        vecs[2] = '{16'h1830, 16'h1234, 1, 6, 8'h03, 1'b0, 16'h0000, RW_WRITE, 8'h30, 16'h1234};
        vecs[3] = '{16'h0455, 16'h0000, 0, 3, 8'h04, 1'b0, 16'h0000, RW_READ,  8'h03, 16'h0455};
        vecs[4] = '{16'h0040, 16'h0000, 0, 4, 8'h05, 1'b1, 16'hA5A5, RW_READ,  8'h40, 16'hA5A5};
        vecs[5] = '{16'h1041, 16'h5AC3, 0, 4, 8'h06, 1'b0, 16'h0000, RW_WRITE, 8'h41, 16'h5AC3};
        vecs[6] = '{16'h2307, 16'h0000, 3, 6, 8'h07, 1'b0, 16'h0000, RW_READ,  8'h06, 16'h2307};
        vecs[7] = '{16'h0041, 16'h0000, 0, 4, 8'h08, 1'b1, 16'h5AC3, RW_READ,  8'h41, 16'h5AC3};

        applyReset();
        run = 1'b1;

        // Table run: each gap is measured in cycles from the previous
        // execute strobe (or from raising run in IDLE) to this one.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].waits, vecs[i].stData);
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
            end while (!inst_valid && gap < 100);
            checkOutput($sformatf("v%0d gap", i),      32'(gap),         32'(vecs[i].expGap));
            checkOutput($sformatf("v%0d inst", i),     32'(inst),        32'(vecs[i].word));
            checkOutput($sformatf("v%0d pc", i),       32'(pc),          32'(vecs[i].expPc));
            checkOutput($sformatf("v%0d ld_valid", i), 32'(ld_valid),    32'(vecs[i].expLdValid));
            if (vecs[i].expLdValid) begin
                checkOutput($sformatf("v%0d ld_data", i), 32'(ld_data), 32'(vecs[i].expLdData));
            end
            checkOutput($sformatf("v%0d txn_rw", i),   32'(lastTxnRw),   32'(vecs[i].expRw));
            checkOutput($sformatf("v%0d txn_addr", i), 32'(lastTxnAddr), 32'(vecs[i].expAddr));
            checkOutput($sformatf("v%0d txn_data", i), 32'(lastTxnData), 32'(vecs[i].expData));
            checkOutput($sformatf("v%0d halted", i),   32'(halted),      32'h0);
        end

        // run dropped in EXEC: the sequencer parks in IDLE.
        run = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idle mem_req",    32'(memIf.mem_req), 32'h0);
        checkOutput("idle inst_valid", 32'(inst_valid),    32'h0);
        checkOutput("idle pc",         32'(pc),            32'h08);
        checkOutput("mem[0x30]",       32'(memArr[8'h30]), 32'h1234);

        // HALT at address 255 with PC wrap, hold, then restart.
        for (int a = 0; a < 255; a++) memArr[a] = 16'h2000;
        memArr[255] = 16'hF000;
        applyStimulus(0, 16'h0000);
        applyReset();
        run    = 1'b1;
        pulses = 0;
        n      = 0;
        while (!halted && n < 2000) begin
            @(negedge clk);
            n++;
            if (inst_valid) pulses++;
        end
        checkOutput("halt reached",    32'(halted),     32'h1);
        checkOutput("halt pulses",     32'(pulses),     32'd255);
        checkOutput("halt pc wrap",    32'(pc),         32'h00);
        checkOutput("halt inst",       32'(inst),       32'hF000);
        checkOutput("halt inst_valid", 32'(inst_valid), 32'h0);
        sawReq = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (memIf.mem_req) sawReq = 1'b1;
        end
        checkOutput("halt hold", 32'(halted), 32'h1);
        checkOutput("halt noreq", 32'(sawReq), 32'h0);
        run = 1'b0;
        @(negedge clk);
        checkOutput("halt leave", 32'(halted), 32'h0);
        run = 1'b1;
        n   = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!memIf.mem_req && n < 10);
        checkOutput("restart fetch req",  32'(memIf.mem_req),  32'h1);
        checkOutput("restart fetch addr", 32'(memIf.mem_addr), 32'h00);
        n = 0;
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput("restart inst_valid", 32'(inst_valid), 32'h1);
        checkOutput("restart inst",       32'(inst),       32'h2000);
        checkOutput("restart pc",         32'(pc),         32'h01);

        // Fetch that is never acknowledged: 64 request cycles then HALT.
        ackEnable = 1'b0;
        applyReset();
        run       = 1'b1;
        reqCycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (memIf.mem_req) reqCycles++;
            else if (reqCycles > 0) break;
        end
        checkOutput("timeout req cycles", 32'(reqCycles),      32'd64);
        checkOutput("timeout mem_req",    32'(memIf.mem_req),  32'h0);
        checkOutput("timeout bus_err",    32'(bus_err),        32'h1);
        checkOutput("timeout halted",     32'(halted),         32'h1);
        run = 1'b0;
        @(negedge clk);
        checkOutput("timeout idle",   32'(halted),  32'h0);
        checkOutput("bus_err sticky", 32'(bus_err), 32'h1);
        run = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("pending fetch req", 32'(memIf.mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkAllZero("async reset");
        checkOutput("protocol errors", 32'(protoErrors), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
